// File: rtl/program_sequencer.sv
// Program sequencer: holds the fetch address and advances it by increment, skip,
// jump, relative branch, or call/return through an internal return-address stack.
module program_sequencer #(
   parameter int          ADDR_W      = 6,
   parameter int          OFF_W       = 8,
   parameter int          STACK_DEPTH = 4,
   parameter int unsigned RESET_ADDR  = 0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             pc_enable,
   input  logic [2:0]                       op,
   input  logic                             cond,
   input  logic [OFF_W-1:0]                 offset,
   input  logic [ADDR_W-1:0]                target,
   input  logic                             clear_fault,
   output logic [ADDR_W-1:0]                instruction_addr,
   output logic [$clog2(STACK_DEPTH+1)-1:0] stack_depth,
   output logic                             stack_ovf,
   output logic                             stack_unf
);

   localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
   localparam int PTR_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   typedef enum logic [2:0] {
      OP_NEXT   = 3'b000,
      OP_SKIP   = 3'b001,
      OP_JUMP   = 3'b010,
      OP_BRANCH = 3'b011,
      OP_CALL   = 3'b100,
      OP_RET    = 3'b101
   } seqOp_t;

   logic [ADDR_W-1:0]  r_pc;
   logic [DEPTH_W-1:0] r_depth;
   logic               r_ovf;
   logic               r_unf;
   logic               r_firstCycle;
   logic [ADDR_W-1:0]  r_stack [STACK_DEPTH];

   logic               w_update;
   logic [ADDR_W-1:0]  w_pc1;
   logic [ADDR_W-1:0]  w_offsetSum;
   logic               w_full;
   logic               w_empty;
   logic [PTR_W-1:0]   w_pushIdx;
   logic [PTR_W-1:0]   w_popIdx;
   logic [ADDR_W-1:0]  w_nextPc;
   logic               w_push;
   logic               w_pop;
   logic               w_ovfEvent;
   logic               w_unfEvent;

   assign w_update    = pc_enable | r_firstCycle;
   assign w_pc1       = r_pc + ADDR_W'(1);
   // Adding in the wider offset domain and truncating gives two's-complement wrap for branches.
   assign w_offsetSum = ADDR_W'(OFF_W'(r_pc) + offset);
   assign w_full      = (r_depth == DEPTH_W'(STACK_DEPTH));
   assign w_empty     = (r_depth == '0);
   assign w_pushIdx   = PTR_W'(r_depth);
   assign w_popIdx    = PTR_W'(r_depth - DEPTH_W'(1));

   always_comb begin
      w_nextPc   = w_pc1;
      w_push     = 1'b0;
      w_pop      = 1'b0;
      w_ovfEvent = 1'b0;
      w_unfEvent = 1'b0;
      case (seqOp_t'(op))
         OP_SKIP: begin
            if (offset[ADDR_W-1:0] != '0) w_nextPc = w_offsetSum;
         end
         OP_JUMP: begin
            if (cond) w_nextPc = target;
         end
         OP_BRANCH: begin
            if (cond) w_nextPc = w_offsetSum;
         end
         OP_CALL: begin
            if (cond) begin
               if (w_full) begin
                  w_ovfEvent = 1'b1;
               end else begin
                  w_push   = 1'b1;
                  w_nextPc = target;
               end
            end
         end
         OP_RET: begin
            if (cond) begin
               if (w_empty) begin
                  w_unfEvent = 1'b1;
               end else begin
                  w_pop    = 1'b1;
                  w_nextPc = r_stack[w_popIdx];
               end
            end
         end
         default: w_nextPc = w_pc1;
      endcase
   end

   // Fault clear applies on every edge; a fault raised on the same edge wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc         <= ADDR_W'(RESET_ADDR);
         r_depth      <= '0;
         r_ovf        <= 1'b0;
         r_unf        <= 1'b0;
         r_firstCycle <= 1'b1;
      end else begin
         r_ovf <= (r_ovf & ~clear_fault) | (w_update & w_ovfEvent);
         r_unf <= (r_unf & ~clear_fault) | (w_update & w_unfEvent);
         if (w_update) begin
            r_pc         <= w_nextPc;
            r_firstCycle <= 1'b0;
            if (w_push) r_depth <= r_depth + DEPTH_W'(1);
            else if (w_pop) r_depth <= r_depth - DEPTH_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_update && w_push) r_stack[w_pushIdx] <= w_pc1;
   end

   assign instruction_addr = r_pc;
   assign stack_depth      = r_depth;
   assign stack_ovf        = r_ovf;
   assign stack_unf        = r_unf;

endmodule

// File: tb/tb_program_sequencer.sv
// Randomised and directed bench for program_sequencer, checked against an
// arithmetic model that keeps the return stack as a queue.
module tb_program_sequencer;

   localparam int ADDR_W = 6;
   localparam int OFF_W  = 8;
   localparam int DEPTH  = 4;
   localparam int MOD    = 64;

   localparam logic [2:0] OP_NEXT = 3'd0, OP_SKIP = 3'd1, OP_JUMP = 3'd2,
                          OP_BRANCH = 3'd3, OP_CALL = 3'd4, OP_RET = 3'd5;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              pcEnable = 1'b0;
   logic [2:0]        opIn = OP_NEXT;
   logic              condIn = 1'b0;
   logic [OFF_W-1:0]  offsetIn = '0;
   logic [ADDR_W-1:0] targetIn = '0;
   logic              clearFault = 1'b0;
   logic [ADDR_W-1:0] oAddr;
   logic [2:0]        oDepth;
   logic              oOvf;
   logic              oUnf;

   int nChecks = 0;
   int nFail   = 0;

   // Behavioural model state
   int mPc = 0;
   int mQ[$];
   bit mOvf = 0, mUnf = 0, mFirst = 1;

   program_sequencer #(.ADDR_W(ADDR_W), .OFF_W(OFF_W), .STACK_DEPTH(DEPTH), .RESET_ADDR(0)) dut (
      .clk(clk), .rst(rst), .pc_enable(pcEnable), .op(opIn), .cond(condIn),
      .offset(offsetIn), .target(targetIn), .clear_fault(clearFault),
      .instruction_addr(oAddr), .stack_depth(oDepth), .stack_ovf(oOvf), .stack_unf(oUnf)
   );

   always #5 clk = ~clk;

   function automatic void modelReset();
      mPc = 0; mQ.delete(); mOvf = 0; mUnf = 0; mFirst = 1;
   endfunction

   function automatic void modelStep(int o, bit c, int off, int tg, bit en, bit clr);
      int pc1, np, disp;
      if (clr) begin mOvf = 0; mUnf = 0; end
      if (!(en || mFirst)) return;
      mFirst = 0;
      pc1 = (mPc + 1) % MOD;
      np = pc1;
      case (o)
         1: if (off % MOD != 0) np = (mPc + off % MOD) % MOD;
         2: if (c) np = tg;
         3: if (c) begin
               disp = (off >= 128) ? off - 256 : off;
               np = ((mPc + disp) % MOD + MOD) % MOD;
            end
         4: if (c) begin
               if (mQ.size() < DEPTH) begin mQ.push_back(pc1); np = tg; end
               else mOvf = 1;
            end
         5: if (c) begin
               if (mQ.size() > 0) np = mQ.pop_back();
               else mUnf = 1;
            end
         default: np = pc1;
      endcase
      mPc = np;
   endfunction

   task automatic applyStimulus(input logic [2:0] o, input logic c, input logic [7:0] off,
                                input logic [5:0] tg, input logic en, input logic clr);
      @(negedge clk);
      opIn = o; condIn = c; offsetIn = off; targetIn = tg; pcEnable = en; clearFault = clr;
      @(posedge clk);
      modelStep(int'(o), c, int'(off), int'(tg), en, clr);
      #1;
   endtask

   task automatic test_reset();
      #3;
      nChecks++;
      if ({oAddr, oDepth, oOvf, oUnf} !== {6'(0), 3'(0), 1'b0, 1'b0}) begin
         nFail++;
         $display("[TB] FAIL reset_state: got pc=%0d depth=%0d ovf=%b unf=%b, expected 0 0 0 0",
                  oAddr, oDepth, oOvf, oUnf);
      end
      @(negedge clk);
      rst = 1'b0;
      modelReset();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(OP_NEXT, 1'b0, 8'h00, 6'd0, 1'b0, 1'b0);
         nChecks++;
         if ({oAddr, oDepth, oOvf, oUnf} !== {6'(mPc), 3'(mQ.size()), mOvf, mUnf} || oAddr !== 6'd1) begin
            nFail++;
            $display("[TB] FAIL first_cycle[%0d]: got pc=%0d, expected pc=1 (model %0d)", i, oAddr, mPc);
         end
      end
   endtask

   task automatic test_sequential();
      logic [2:0] ops [6]  = '{OP_JUMP, OP_NEXT, OP_NEXT, OP_SKIP, OP_JUMP, OP_SKIP};
      logic [7:0] offs [6] = '{8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h03};
      logic [5:0] tgts [6] = '{6'd62, 6'd0, 6'd0, 6'd0, 6'd10, 6'd0};
      for (int i = 0; i < 6; i++) begin
         applyStimulus(ops[i], 1'b1, offs[i], tgts[i], 1'b1, 1'b0);
         nChecks++;
         if ({oAddr, oDepth, oOvf, oUnf} !== {6'(mPc), 3'(mQ.size()), mOvf, mUnf}) begin
            nFail++;
            $display("[TB] FAIL seq_skip[%0d]: got pc=%0d depth=%0d, expected pc=%0d depth=%0d",
                     i, oAddr, oDepth, mPc, mQ.size());
         end
      end
   endtask

   task automatic test_branch();
      logic [2:0] ops [5]  = '{OP_JUMP, OP_BRANCH, OP_JUMP, OP_BRANCH, OP_JUMP};
      logic       cnds [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [5:0] tgts [5] = '{6'd5, 6'd0, 6'd5, 6'd0, 6'd40};
      for (int i = 0; i < 5; i++) begin
         applyStimulus(ops[i], cnds[i], 8'hFD, tgts[i], 1'b1, 1'b0);
         nChecks++;
         if ({oAddr, oDepth, oOvf, oUnf} !== {6'(mPc), 3'(mQ.size()), mOvf, mUnf}) begin
            nFail++;
            $display("[TB] FAIL branch[%0d]: got pc=%0d, expected pc=%0d", i, oAddr, mPc);
         end
      end
   endtask

   task automatic test_stack();
      logic [2:0] ops [10];
      logic [5:0] tgts [10] = '{6'd3, 6'd20, 6'd30, 6'd40, 6'd50, 6'd60, 6'd0, 6'd0, 6'd0, 6'd0};
      for (int i = 0; i < 10; i++) ops[i] = (i == 0) ? OP_JUMP : (i <= 5) ? OP_CALL : OP_RET;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(ops[i], 1'b1, 8'h00, tgts[i], 1'b1, 1'b0);
         nChecks++;
         if ({oAddr, oDepth, oOvf, oUnf} !== {6'(mPc), 3'(mQ.size()), mOvf, mUnf}) begin
            nFail++;
            $display("[TB] FAIL stack[%0d]: got pc=%0d depth=%0d ovf=%b, expected pc=%0d depth=%0d ovf=%b",
                     i, oAddr, oDepth, oOvf, mPc, mQ.size(), mOvf);
         end
      end
   endtask

   task automatic test_faults();
      logic [2:0] ops [4] = '{OP_JUMP, OP_RET, OP_NEXT, OP_RET};
      logic       ens [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
      logic       clr [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 4; i++) begin
         applyStimulus(ops[i], 1'b1, 8'h00, 6'd7, ens[i], clr[i]);
         nChecks++;
         if ({oAddr, oDepth, oOvf, oUnf} !== {6'(mPc), 3'(mQ.size()), mOvf, mUnf}) begin
            nFail++;
            $display("[TB] FAIL faults[%0d]: got pc=%0d ovf=%b unf=%b, expected pc=%0d ovf=%b unf=%b",
                     i, oAddr, oOvf, oUnf, mPc, mOvf, mUnf);
         end
      end
   endtask

   task automatic test_async_reset();
      applyStimulus(OP_JUMP, 1'b1, 8'h00, 6'd31, 1'b1, 1'b0);
      applyStimulus(OP_CALL, 1'b1, 8'h00, 6'd40, 1'b1, 1'b0);
      applyStimulus(OP_CALL, 1'b1, 8'h00, 6'd32, 1'b1, 1'b0);
      applyStimulus(OP_NEXT, 1'b0, 8'h00, 6'd0, 1'b1, 1'b0);
      nChecks++;
      if (oAddr !== 6'd33 || oDepth !== 3'd2) begin
         nFail++;
         $display("[TB] FAIL pre_reset: got pc=%0d depth=%0d, expected pc=33 depth=2", oAddr, oDepth);
      end
      #2 rst = 1'b1;
      modelReset();
      #1;
      nChecks++;
      if ({oAddr, oDepth, oOvf, oUnf} !== {6'(0), 3'(0), 1'b0, 1'b0}) begin
         nFail++;
         $display("[TB] FAIL async_reset: got pc=%0d depth=%0d ovf=%b unf=%b, expected 0 0 0 0",
                  oAddr, oDepth, oOvf, oUnf);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         applyStimulus(OP_NEXT, 1'b0, 8'h00, 6'd0, 1'b0, 1'b0);
         nChecks++;
         if ({oAddr, oDepth, oOvf, oUnf} !== {6'(mPc), 3'(mQ.size()), mOvf, mUnf} || oAddr !== 6'd1) begin
            nFail++;
            $display("[TB] FAIL post_reset[%0d]: got pc=%0d, expected pc=1", i, oAddr);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         applyStimulus(3'($urandom_range(0, 7)), ($urandom % 4) != 0, 8'($urandom),
                       6'($urandom), ($urandom % 4) != 0, ($urandom % 10) == 0);
         nChecks++;
         if ({oAddr, oDepth, oOvf, oUnf} !== {6'(mPc), 3'(mQ.size()), mOvf, mUnf}) begin
            nFail++;
            $display("[TB] FAIL random[%0d]: got pc=%0d depth=%0d ovf=%b unf=%b, expected pc=%0d depth=%0d ovf=%b unf=%b",
                     i, oAddr, oDepth, oOvf, oUnf, mPc, mQ.size(), mOvf, mUnf);
         end
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch();
      test_stack();
      test_faults();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
